// File: rtl/mips_mc_core_if.sv
// +--------------------------------------------------------------------+
// | Module   : mips_mc_core_if                                         |
// | Brief    : Unified memory bus (req/ack handshake) for mips_mc_core |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface mips_mc_core_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  // Core side: issues requests, receives read data and completion
  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Memory side: services requests
  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/mips_mc_core.sv
// +--------------------------------------------------------------------+
// | Module   : mips_mc_core                                            |
// | Brief    : Multicycle MIPS-subset core (lw/sw/R/beq/j/addi) on a   |
// |            single req/ack memory port of arbitrary latency.        |
// | Options  : OVF_TRAP_EN - signed overflow on add/sub/addi halts the |
// |            core instead of writing back the wrapped result.        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module mips_mc_core #(
  parameter int               WIDTH    = 32,
  parameter int               REGBITS  = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  mips_mc_core_if.master   bus,
  output logic [WIDTH-1:0] pc_out,
  output logic             halted
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;
  localparam int         c_MSB      = WIDTH - 1;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_RTWB, S_BEQ, S_JMP, S_ADDIEX, S_ADDIWB, S_HALT
  } state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_pc, r_a, r_b, r_alu, r_mdr, r_adr, r_wdata;
  logic [31:0]        r_ir;
  logic               r_req, r_we;
  logic [WIDTH-1:0]   r_rf [0:(1<<REGBITS)-1];

  logic [5:0]         w_op, w_funct;
  logic [REGBITS-1:0] w_rs, w_rt, w_rd, w_rf_wa;
  logic [WIDTH-1:0]   w_imm, w_ea, w_alu_res, w_pc_next, w_rs_val, w_rt_val, w_rf_wd;
  logic               w_ack_ok, w_funct_ok, w_rf_we, w_unused_ok;

  assign w_op     = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  assign w_rs     = REGBITS'(r_ir[25:21]);
  assign w_rt     = REGBITS'(r_ir[20:16]);
  assign w_rd     = REGBITS'(r_ir[15:11]);
  assign w_imm    = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign w_ea     = r_a + w_imm;
  // An ack only counts while a request is actually outstanding
  assign w_ack_ok = r_req & bus.mem_ack;
  assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];
  assign w_unused_ok = ^r_ir[10:6];

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_adr   = r_adr;
  assign bus.mem_wdata = r_wdata;
  assign pc_out        = r_pc;
  assign halted        = (r_state == S_HALT);

  // R-type ALU; flags unsupported funct codes
  always_comb begin
    w_alu_res  = r_a + r_b;
    w_funct_ok = 1'b1;
    case (w_funct)
      c_FN_ADD: w_alu_res = r_a + r_b;
      c_FN_SUB: w_alu_res = r_a - r_b;
      c_FN_AND: w_alu_res = r_a & r_b;
      c_FN_OR:  w_alu_res = r_a | r_b;
      c_FN_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default:  w_funct_ok = 1'b0;
    endcase
  end

`ifdef OVF_TRAP_EN
  logic w_ovf_rt, w_ovf_addi;
  // Signed overflow: operands agree in sign (after negating B for sub) but result does not
  assign w_ovf_rt = ((w_funct == c_FN_ADD) && (r_a[c_MSB] == r_b[c_MSB]) &&
                     (w_alu_res[c_MSB] != r_a[c_MSB])) ||
                    ((w_funct == c_FN_SUB) && (r_a[c_MSB] != r_b[c_MSB]) &&
                     (w_alu_res[c_MSB] != r_a[c_MSB]));
  assign w_ovf_addi = (r_a[c_MSB] == w_imm[c_MSB]) && (w_ea[c_MSB] != r_a[c_MSB]);
`endif

  // Main control: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ack_ok) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_RTEX;
          c_OP_BEQ:         w_next = S_BEQ;
          c_OP_J:           w_next = S_JMP;
          c_OP_ADDI:        w_next = S_ADDIEX;
          default:          w_next = S_HALT;
        endcase
      end
      S_MEMADR: w_next = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_ack_ok) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_ack_ok) w_next = S_FETCH;
      S_RTEX: begin
        if (!w_funct_ok) w_next = S_HALT;
`ifdef OVF_TRAP_EN
        else if (w_ovf_rt) w_next = S_HALT;
`endif
        else w_next = S_RTWB;
      end
      S_RTWB:   w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_JMP:    w_next = S_FETCH;
`ifdef OVF_TRAP_EN
      S_ADDIEX: w_next = w_ovf_addi ? S_HALT : S_ADDIWB;
`else
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      S_ADDIWB: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  // PC update: sequential increment on fetch, branch target, jump target
  always_comb begin
    w_pc_next = r_pc;
    case (r_state)
      S_FETCH: if (w_ack_ok) w_pc_next = r_pc + WIDTH'(4);
      S_BEQ:   if (r_a == r_b) w_pc_next = r_alu;
      S_JMP:   w_pc_next = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  // Register-file write port selection
  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wa = w_rt;
    w_rf_wd = r_alu;
    case (r_state)
      S_MEMWB:  begin w_rf_we = 1'b1; w_rf_wd = r_mdr; end
      S_RTWB:   begin w_rf_we = 1'b1; w_rf_wa = w_rd; end
      S_ADDIWB: w_rf_we = 1'b1;
      default:  w_rf_we = 1'b0;
    endcase
  end

  // Register file: not reset, r0 never written
  always_ff @(posedge clk) begin
    if (w_rf_we && (w_rf_wa != '0)) r_rf[w_rf_wa] <= w_rf_wd;
  end

  // State, datapath registers and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      case (r_state)
        S_FETCH:  if (w_ack_ok) r_ir <= bus.mem_rdata[31:0];
        S_DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_alu <= r_pc + (w_imm << 2);
        end
        S_MEMADR: r_alu <= w_ea;
        S_ADDIEX: r_alu <= w_ea;
        S_MEMRD:  if (w_ack_ok) r_mdr <= bus.mem_rdata;
        S_RTEX:   r_alu <= w_alu_res;
        default:  ;
      endcase
      // Request is presented together with the access state, so it is already
      // stable when that state is entered and drops as soon as the state is left
      r_req <= (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);
      r_we  <= (w_next == S_MEMWR);
      if (w_next == S_FETCH) r_adr <= w_pc_next;
      else if ((w_next == S_MEMRD) || (w_next == S_MEMWR)) r_adr <= w_ea;
      if (w_next == S_MEMWR) r_wdata <= r_b;
    end
  end

endmodule

`default_nettype wire
